// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported RAM between the fetch (if_*) and data (d_*) requesters.
// Latency: gnt at T, mem_en at T+1, rdata captured end of T+1+MEM_LAT, rvalid at T+2+MEM_LAT; one access per MEM_LAT+3 cycles.
// Backpressure: one access in flight; requests wait (unlost) while busy as long as req stays high until gnt.
// Ports: clk/rst (sync, active-high); if_req/if_addr/if_flush -> if_gnt/if_rvalid/if_rdata;
//        d_req/d_we/d_addr/d_wdata -> d_gnt/d_rvalid/d_rdata; mem_en/we/addr/wdata -> RAM, mem_rdata <- RAM;
//        busy is high whenever the sequencer is not IDLE.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int             SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]  STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [3:0]     LAT        = 4'(MEM_LAT);

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [3:0]    lat_cnt;
  logic          own_if;      // access belongs to the fetch side
  logic          own_we;      // access is a store
  logic          flush_pend;
  logic          pick_if;

  // Data wins a tie unless fetch has been passed over STARVE_MAX times in a row.
  // Grants are held low during reset so nothing is promised that will not be latched.
  always_comb begin
    pick_if = if_req && (!d_req || starve_cnt == STARVE_LIM);
    if_gnt  = 1'b0;
    d_gnt   = 1'b0;
    if (state == IDLE && !rst) begin
      if_gnt = pick_if;
      d_gnt  = d_req && !pick_if;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lat_cnt    <= '0;
      own_if     <= 1'b0;
      own_we     <= 1'b0;
      flush_pend <= 1'b0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      // RAM port and rvalids are single-cycle; they idle at zero unless set below.
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;

      if (state != IDLE && own_if && if_flush) flush_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (if_gnt || d_gnt) begin
            // The mem_* registers double as the latched request for the ISSUE cycle.
            own_if    <= if_gnt;
            own_we    <= d_gnt & d_we;
            mem_en    <= 1'b1;
            mem_we    <= d_gnt & d_we;
            mem_addr  <= if_gnt ? if_addr : d_addr;
            mem_wdata <= (d_gnt & d_we) ? d_wdata : '0;
            busy      <= 1'b1;
            state     <= ISSUE;
            if (if_gnt)
              starve_cnt <= '0;
            else if (if_req && starve_cnt != STARVE_LIM)
              starve_cnt <= starve_cnt + 1'b1;
          end
        end
        ISSUE: begin
          lat_cnt <= LAT;
          state   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == 4'd1) begin
            // A flush seen in this last WAIT cycle must still suppress the response.
            if (own_if) begin
              if_rdata  <= mem_rdata;
              if_rvalid <= !(flush_pend || if_flush);
            end else begin
              if (!own_we) d_rdata <= mem_rdata;
              d_rvalid <= 1'b1;
            end
            state <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RESP: begin
          flush_pend <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares the single-ported unified RAM between the instruction-fetch stage and the data (load/store) stage of the pipelined TOP processor. It accepts one request at a time, drives the RAM port for one cycle, waits the fixed RAM read latency and returns the result to the owning requester. Data accesses have priority, with a starvation guard that forces a fetch grant, and a flush input that cancels a pending fetch.

## Interface
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 2, RAM read latency in cycles from mem_en to valid mem_rdata; legal range 1..15
- STARVE_MAX, 3, consecutive data grants made while if_req is high before fetch is forced; legal range ≥1

- clk  in  1  single system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request; addr stable while high
- if_addr  in  AW  fetch address
- if_flush  in  1  cancel the in-flight fetch response
- if_gnt  out  1  fetch request accepted (one-cycle pulse)
- if_rvalid  out  1  fetch data valid (one-cycle pulse)
- if_rdata  out  DW  fetch read data
- d_req  in  1  data request; we/addr/wdata stable while high
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_gnt  out  1  data request accepted (one-cycle pulse)
- d_rvalid  out  1  data access complete (load data valid, or store done)
- d_rdata  out  DW  load data
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid MEM_LAT cycles after mem_en
- busy  out  1  high in every state except IDLE

## Operation
- FSM: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE: if a request is pending, assert the winner's gnt combinationally and latch owner, we, addr and wdata at the clock edge. Go to ISSUE. With no request, stay in IDLE.
- Winner selection: only one requester → it wins. Both requesters → d wins, unless starve_cnt == STARVE_MAX, in which case if wins.
- starve_cnt: increments (saturating at STARVE_MAX) on each d grant while if_req = 1. Clears to 0 on each if grant. Holds otherwise.
- ISSUE (1 cycle): mem_en = 1, mem_we/mem_addr/mem_wdata from the latched values. Fetch always has mem_we = 0. Load mem_wdata = 0. Counter loads MEM_LAT.
- WAIT (MEM_LAT cycles): counter decrements. On the final cycle, mem_rdata is captured into the owner's rdata register. Store accesses capture nothing.
- RESP (1 cycle): owner's rvalid = 1.
  - A store pulses d_rvalid; d_rdata holds its previous value.
  - If the owner is if and a flush is pending, if_rvalid is suppressed but if_rdata is still updated.
- Flush: if_flush = 1 in any cycle of ISSUE/WAIT/RESP while if owns the access sets flush_pend. flush_pend clears on return to IDLE. if_flush in IDLE, or while d owns the access, is ignored.
- Outputs are registered except if_gnt/d_gnt, which are combinational from IDLE state, requests and starve_cnt.
- mem_en, mem_we, mem_addr and mem_wdata are 0 outside ISSUE.

## Timing
- Reset (rst sampled high at a rising edge):
  - state = IDLE, starve_cnt = 0, flush_pend = 0.
  - All outputs 0, including if_rdata and d_rdata.
  - An in-flight access is abandoned with no rvalid.
  - A request held through reset is granted in the first IDLE cycle after rst falls.
- Gnt in cycle T → mem_en in T+1 → mem_rdata captured at end of T+1+MEM_LAT → rvalid in T+2+MEM_LAT → next gnt earliest T+3+MEM_LAT.
- MEM_LAT = 2: gnt T, mem_en T+1, rvalid T+4, next gnt T+5. Throughput is one access per MEM_LAT+3 cycles.
- A requester may drop req the cycle after gnt. A req still high after rvalid is treated as a new request.
- Requests arriving while busy wait; they are never lost provided req stays high.
- At most one of if_gnt/d_gnt is high; at most one of if_rvalid/d_rvalid is high.

## Test plan
- Reset then single fetch: if_req = 1, if_addr = 0x10, RAM word 0x10 = 0xDEADBEEF → if_gnt at T, mem_en/mem_addr = 0x10 at T+1, if_rvalid with if_rdata = 0xDEADBEEF at T+4.
- Store then load: d_we = 1, d_addr = 0x20, d_wdata = 0x12345678, then a load from 0x20 → mem_we = 1 on the first ISSUE, d_rvalid at T+4 with d_rdata unchanged; the load returns 0x12345678 at rvalid.
- Contention: if_req and d_req held high continuously → grant order d, d, d, if, d, d, d, if…; starve_cnt reads 3 at each forced fetch grant.
- Flush: a fetch is granted, then if_flush = 1 in WAIT → no if_rvalid, if_rdata updated; a following d access behaves normally.
- Reset mid-access: rst = 1 during WAIT → next cycle all outputs 0, no rvalid ever for that access; a held d_req is granted in the first cycle after rst releases.
- Parameter sweep MEM_LAT = 1 and MEM_LAT = 5 → rvalid at T+3 and T+7 respectively; busy high from T+1 through rvalid.
